// File: rtl/cpu_pio_arb_pkg.sv
// Shared types and constants for the CPU output-PIO write arbiter.
package cpu_pio_arb_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_SET     = 2'b01,
        OP_CLEAR   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    function automatic logic [2:0] op_addr(input op_e op);
        case (op)
            OP_SET:   return ADDR_OUTSET;
            OP_CLEAR: return ADDR_OUTCLR;
            default:  return ADDR_DATA;
        endcase
    endfunction

endpackage

// File: rtl/cpu_pio_arbiter_if.sv
// Requester handshake plus PIO s1 write port and shadow, shared by the arbiter and its users.
interface cpu_pio_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned WIDTH   = 2
);
    logic [NUM_REQ-1:0]       req;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]       gnt;
    logic                     err;
    logic [2:0]               pio_address;
    logic                     pio_chipselect;
    logic                     pio_write_n;
    logic [31:0]              pio_writedata;
    logic [WIDTH-1:0]         shadow;

    modport master (
        output req, req_op, req_data,
        input  gnt, err, pio_address, pio_chipselect, pio_write_n, pio_writedata, shadow
    );

    modport slave (
        input  req, req_op, req_data,
        output gnt, err, pio_address, pio_chipselect, pio_write_n, pio_writedata, shadow
    );
endinterface

// File: rtl/cpu_pio_rr_picker.sv
// Combinational winner select: masked requesters win lowest-index first, the rest round-robin from ptr.
module cpu_pio_rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] prio_mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);
    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] rr;
    logic [IDX_W:0]     cand;

    always_comb begin
        hi     = req & prio_mask;
        rr     = req & ~prio_mask;
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        if (|hi) begin
            // Downward scan so the last hit is the lowest index.
            for (int unsigned k = NUM_REQ; k > 0; k--) begin
                if (hi[k-1]) idx = IDX_W'(k - 1);
            end
            valid = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, ptr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
                if (!valid && rr[cand[IDX_W-1:0]]) begin
                    valid = 1'b1;
                    idx   = cand[IDX_W-1:0];
                end
            end
        end
        if (valid) onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/cpu_pio_arbiter.sv
// Arbitrates atomic write/set/clear requests onto the CPU PIO s1 port and keeps a shadow of its output.
// Define CPU_PIO_ARB_PRIO_EN to give requester 0 absolute priority over the round-robin group.
module cpu_pio_arbiter
    import cpu_pio_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned WIDTH   = 2
) (
    input logic              clk,
    input logic              reset_n,
    cpu_pio_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

`ifdef CPU_PIO_ARB_PRIO_EN
    localparam logic [NUM_REQ-1:0] PRIO_MASK = NUM_REQ'(1);
`else
    localparam logic [NUM_REQ-1:0] PRIO_MASK = '0;
`endif

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               err_q, err_d;
    logic               cs_q, cs_d;
    logic               wr_n_q, wr_n_d;
    logic [2:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               pick_valid;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    op_e                pick_op;
    logic [WIDTH-1:0]   pick_data;

    cpu_pio_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req       (bus.req),
        .prio_mask (PRIO_MASK),
        .ptr       (ptr_q),
        .valid     (pick_valid),
        .onehot    (pick_onehot),
        .idx       (pick_idx)
    );

    always_comb begin
        pick_op   = op_e'(bus.req_op[2*pick_idx +: 2]);
        pick_data = bus.req_data[WIDTH*pick_idx +: WIDTH];

        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        op_d     = op_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        gnt_d    = '0;
        err_d    = 1'b0;
        cs_d     = 1'b0;
        wr_n_d   = 1'b1;
        addr_d   = ADDR_DATA;
        wdata_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ISSUE;
                    win_d   = pick_idx;
                    op_d    = pick_op;
                    data_d  = pick_data;
                    gnt_d   = pick_onehot;
                    if (pick_op == OP_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        cs_d                 = 1'b1;
                        wr_n_d               = 1'b0;
                        addr_d               = op_addr(pick_op);
                        wdata_d[WIDTH-1:0]   = pick_data;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
                case (op_q)
                    OP_WRITE: shadow_d = data_q;
                    OP_SET:   shadow_d = shadow_q | data_q;
                    OP_CLEAR: shadow_d = shadow_q & ~data_q;
                    default:  ;
                endcase
                // A priority-class winner leaves the round-robin position untouched.
                if (!PRIO_MASK[win_q]) begin
                    if (int'(win_q) == NUM_REQ - 1) ptr_d = '0;
                    else                           ptr_d = win_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            op_q     <= OP_WRITE;
            data_q   <= '0;
            shadow_q <= '0;
            gnt_q    <= '0;
            err_q    <= 1'b0;
            cs_q     <= 1'b0;
            wr_n_q   <= 1'b1;
            addr_q   <= ADDR_DATA;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            op_q     <= op_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            gnt_q    <= gnt_d;
            err_q    <= err_d;
            cs_q     <= cs_d;
            wr_n_q   <= wr_n_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.gnt            = gnt_q;
    assign bus.err            = err_q;
    assign bus.pio_chipselect = cs_q;
    assign bus.pio_write_n    = wr_n_q;
    assign bus.pio_address    = addr_q;
    assign bus.pio_writedata  = wdata_q;
    assign bus.shadow         = shadow_q;
endmodule
